// File: rtl/radar_stim_pkg.sv
// Shared state codes, width helpers and the ramp-sample function for the
// radar frame stimulus generator.
package radar_stim_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_CHIRP  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Index width for a counter running 0..count-1 (never narrower than 1 bit).
    function automatic int idx_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // Width for a down-counter loaded with values up to max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    // Ramp value before truncation to the channel width.
    function automatic logic [31:0] ramp_sample(input logic [31:0] chirp,
                                                input logic [31:0] n,
                                                input logic [31:0] k,
                                                input logic [31:0] samples,
                                                input logic [31:0] ch_offset);
        return chirp * samples + n + k * ch_offset;
    endfunction

endpackage

// File: rtl/radar_stim_chan.sv
// One channel of sample data: loads a new value when a beat advances and
// holds it while the stream is stalled.
module radar_stim_chan #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Data register with hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/radar_stim_gen.sv
// Radar frame stimulus generator: warm-up, then frames of ramp-data chirps on
// an AXI-Stream master with backpressure. All outputs are registered.
module radar_stim_gen
    import radar_stim_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int SAMPLES   = 256,
    parameter int CHIRPS    = 32,
    parameter int PRI_GAP   = 64,
    parameter int RST_HOLD  = 250,
    parameter int CH_OFFSET = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [15:0]                frames_req,
    output logic [NUM_CH*DATA_W-1:0]   m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic                       m_tuser,
    output logic [idx_w(CHIRPS)-1:0]   chirp_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int SAMPLE_W = idx_w(SAMPLES);
    localparam int CHIRP_W  = idx_w(CHIRPS);
    localparam int WAIT_W   = cnt_w((RST_HOLD > PRI_GAP) ? RST_HOLD : PRI_GAP);

    logic [2:0]          state_r, state_s;
    logic [SAMPLE_W-1:0] n_r, n_s;
    logic [CHIRP_W-1:0]  chirp_s;
    logic [15:0]         frame_r, frame_s;
    logic [15:0]         frames_lat_r, frames_lat_s;
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic                load_s;
    logic                last_beat_s;
    logic                last_chirp_s;

    // Next-state and counter logic; load_s marks every edge that presents a new beat.
    always_comb begin
        state_s      = state_r;
        n_s          = n_r;
        chirp_s      = chirp_idx;
        frame_s      = frame_r;
        frames_lat_s = frames_lat_r;
        wait_s       = wait_r;
        load_s       = 1'b0;
        last_beat_s  = (n_r == SAMPLE_W'(SAMPLES - 1));
        last_chirp_s = (chirp_idx == CHIRP_W'(CHIRPS - 1));
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s      = ST_WARMUP;
                    frames_lat_s = frames_req;
                    wait_s       = WAIT_W'(RST_HOLD);
                    n_s          = '0;
                    chirp_s      = '0;
                    frame_s      = 16'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (wait_r == '0) begin
                    state_s = ST_CHIRP;
                    load_s  = 1'b1;
                end else begin
                    wait_s = wait_r - WAIT_W'(1);
                end
            end
            ST_CHIRP: begin
                if (m_tready) begin
                    if (last_beat_s) begin
                        n_s = '0;
                        if (last_chirp_s) begin
                            chirp_s = '0;
                            frame_s = frame_r + 16'd1;
                        end else begin
                            chirp_s = chirp_idx + CHIRP_W'(1);
                        end
                        if (last_chirp_s && (frames_lat_r != 16'd0) && (frame_s == frames_lat_r)) begin
                            state_s = ST_DONE;
                        end else if (!enable) begin
                            state_s = ST_IDLE;
                        end else if (PRI_GAP == 0) begin
                            state_s = ST_CHIRP;
                            load_s  = 1'b1;
                        end else begin
                            state_s = ST_GAP;
                            wait_s  = WAIT_W'(PRI_GAP - 1);
                        end
                    end else begin
                        n_s    = n_r + SAMPLE_W'(1);
                        load_s = 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (wait_r == '0) begin
                    if (enable) begin
                        state_s = ST_CHIRP;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    wait_s = wait_r - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered stream/status outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            n_r          <= '0;
            chirp_idx    <= '0;
            frame_r      <= 16'd0;
            frames_lat_r <= 16'd0;
            wait_r       <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tuser      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_r      <= state_s;
            n_r          <= n_s;
            chirp_idx    <= chirp_s;
            frame_r      <= frame_s;
            frames_lat_r <= frames_lat_s;
            wait_r       <= wait_s;
            m_tvalid     <= (state_s == ST_CHIRP);
            m_tlast      <= (state_s == ST_CHIRP) && (n_s == SAMPLE_W'(SAMPLES - 1));
            m_tuser      <= (state_s == ST_CHIRP) && (n_s == '0) && (chirp_s == '0);
            busy         <= (state_s inside {ST_WARMUP, ST_CHIRP, ST_GAP});
            done         <= (state_s == ST_DONE);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        logic [DATA_W-1:0] din_s;
        assign din_s = DATA_W'(ramp_sample(32'(chirp_s), 32'(n_s), 32'(k),
                                           32'(SAMPLES), 32'(CH_OFFSET)));
        radar_stim_chan #(.DATA_W(DATA_W)) u_chan (
            .clk   (clk),
            .reset (reset),
            .load  (load_s),
            .din   (din_s),
            .dout  (m_tdata[k*DATA_W +: DATA_W])
        );
    end

endmodule
